conv_window_buffer: RTL
=======================

Name: conv_window_buffer

Overview:
- Parametrised line buffer that turns a raster-order pixel stream into K x K convolution windows for the conv engine.
- Generalises the single 16-bit pipeline register into a valid-qualified shift chain of (K-1)*IMG_W+K words, with row/column tracking, edge suppression, frame resync and frame-done signalling.
- Sits between the input pixel feeder and the MAC array.

Parameters:
- DATA_W, 16, pixel/word width in bits.
- IMG_W, 28, pixels per row.
- IMG_H, 28, rows per frame.
- K, 3, window edge. Legal range is 1 <= K <= min(IMG_W, IMG_H); elaboration error otherwise.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  pixel accepted on any edge where it is high (no backpressure).
- in_sof  in  1  start of frame; qualified by in_valid.
- in_data  in  DATA_W  pixel value.
- win_valid  out  1  one-cycle pulse, win_data holds a legal window.
- win_data  out  K*K*DATA_W  window, element e = r*K+c at bits [e*DATA_W +: DATA_W].
- win_row  out  clog2(IMG_H)  top-left row of the window.
- win_col  out  clog2(IMG_W)  top-left column of the window.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame.

Behaviour:
- Reset (clk, reset: synchronous, active-high):
  - Clears the shift chain, col/row counters, win_valid, win_data, win_row, win_col and frame_done to 0.
  - Reset mid-frame discards the partial frame; the next accepted pixel is (0,0).
- Accept edge (in_valid=1):
  - Pixel position (row,col) comes from the counters, except in_sof=1 forces (0,0).
  - Shift chain: sr[0] <= in_data, sr[i] <= sr[i-1].
  - col increments; at IMG_W-1, col wraps to 0 and row increments.
  - At (IMG_H-1, IMG_W-1), both wrap to 0 and frame_done <= 1.
  - in_sof without in_valid is ignored.
- Idle edge (in_valid=0): chain and counters hold; win_valid <= 0; frame_done <= 0.
- Window generation, registered on the same accept edge (latency 1 cycle from pixel acceptance to win_valid):
  - win_valid <= (row >= K-1) && (col >= K-1). Windows straddling a row edge or the top rows are suppressed.
  - Element (r,c) = pixel(row-(K-1)+r, col-(K-1)+c), taken from post-shift index (K-1-r)*IMG_W + (K-1-c). Index 0 is in_data itself.
  - Element 0 is the top-left pixel; element K*K-1 is the newest pixel.
  - win_row <= row-(K-1); win_col <= col-(K-1).
  - When win_valid <= 0, win_data/win_row/win_col hold their previous values.
- Window count: exactly (IMG_H-K+1)*(IMG_W-K+1) windows per frame, 676 at defaults.
- Frame boundaries:
  - Chain contents are not cleared between frames.
  - Stale data never reaches a valid window because of the row >= K-1 rule.
  - Back-to-back frames need no idle cycle.
- K=1: every accepted pixel produces a window equal to in_data.
- Simultaneous in_sof with the last pixel of a frame: in_sof wins and the pixel is (0,0). frame_done pulses only if the pre-override position was (IMG_H-1, IMG_W-1).

Test Plan:
1. Reset, then stream 784 pixels with value row*28+col, in_valid continuous.
   - First win_valid comes one cycle after pixel 58 is accepted, with elements 0,1,2,28,29,30,56,57,58 and win_row=0, win_col=0.
   - 676 windows total; frame_done pulses once, one cycle after pixel 783.
2. Row edge: pixels (3,0) and (3,1) produce no win_valid.
   - Pixel (3,2) gives win_row=1, win_col=0, elements 28,29,30,56,57,58,84,85,86.
3. Random in_valid gaps (25% idle) over a full frame.
   - Window sequence is identical to scenario 1.
   - win_valid is never high in the cycle after an idle edge.
4. in_sof pulse on the 101st pixel of a frame.
   - Counters resync; that pixel is (0,0).
   - The first window follows 58 pixels later with correct contents.
5. reset asserted for 1 cycle at pixel 400.
   - All outputs are 0 the next cycle.
   - A subsequent full frame yields exactly 676 windows and one frame_done.
6. Two back-to-back frames, second frame values offset by 1000.
   - frame_done pulses twice.
   - Second frame's first window is 1000,1001,1002,1028,1029,1030,1056,1057,1058, with no first-frame data.

Source files
------------

// File: rtl/conv_window_buffer.sv
// Line buffer turning a raster pixel stream into K x K convolution windows.
// Windows are registered one cycle after the newest pixel is accepted; edge windows are suppressed.
module conv_window_buffer #(
   parameter  int DATA_W = 16,
   parameter  int IMG_W  = 28,
   parameter  int IMG_H  = 28,
   parameter  int K      = 3,
   localparam int RW     = (IMG_H > 1) ? $clog2(IMG_H) : 1,
   localparam int CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   input  logic                    in_sof,
   input  logic [DATA_W-1:0]       in_data,
   output logic                    win_valid,
   output logic [K*K*DATA_W-1:0]   win_data,
   output logic [RW-1:0]           win_row,
   output logic [CW-1:0]           win_col,
   output logic                    frame_done
);

   // The newest pixel is consumed straight from in_data, so only N-1 words are stored.
   localparam int CHAIN = (K > 1) ? (K - 1) * IMG_W + K - 1 : 1;

   if (K < 1 || K > IMG_W || K > IMG_H) begin : g_bad_k
      $error("conv_window_buffer: K must satisfy 1 <= K <= min(IMG_W, IMG_H)");
   end

   logic [DATA_W-1:0]     sr_q [CHAIN];
   logic [DATA_W-1:0]     tap  [CHAIN+1];
   logic [RW-1:0]         row_q, row_d, pos_row;
   logic [CW-1:0]         col_q, col_d, pos_col;
   logic                  win_ok, frame_end;
   logic [K*K*DATA_W-1:0] win_d;
   logic                  win_valid_q, frame_done_q;
   logic [K*K*DATA_W-1:0] win_data_q;
   logic [RW-1:0]         win_row_q;
   logic [CW-1:0]         win_col_q;

   always_comb begin
      tap[0] = in_data;
      for (int i = 0; i < CHAIN; i++) begin
         tap[i+1] = sr_q[i];
      end
   end

   always_comb begin
      pos_row   = in_sof ? '0 : row_q;
      pos_col   = in_sof ? '0 : col_q;
      row_d     = row_q;
      col_d     = col_q;
      win_ok    = 1'b0;
      frame_end = 1'b0;
      if (in_valid) begin
         if (pos_col == CW'(IMG_W - 1)) begin
            col_d = '0;
            row_d = (pos_row == RW'(IMG_H - 1)) ? '0 : pos_row + 1'b1;
         end else begin
            col_d = pos_col + 1'b1;
            row_d = pos_row;
         end
         win_ok    = (pos_row >= RW'(K - 1)) && (pos_col >= CW'(K - 1));
         // A resync on the last pixel still closes the frame that was in progress.
         frame_end = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));
      end
   end

   always_comb begin
      win_d = '0;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K; c++) begin
            win_d[(r*K+c)*DATA_W +: DATA_W] = tap[(K-1-r)*IMG_W + (K-1-c)];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < CHAIN; i++) begin
            sr_q[i] <= '0;
         end
         row_q        <= '0;
         col_q        <= '0;
         win_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         win_data_q   <= '0;
         win_row_q    <= '0;
         win_col_q    <= '0;
      end else begin
         win_valid_q  <= win_ok;
         frame_done_q <= frame_end;
         if (in_valid) begin
            sr_q[0] <= in_data;
            for (int i = 1; i < CHAIN; i++) begin
               sr_q[i] <= sr_q[i-1];
            end
            row_q <= row_d;
            col_q <= col_d;
         end
         if (win_ok) begin
            win_data_q <= win_d;
            win_row_q  <= pos_row - RW'(K - 1);
            win_col_q  <= pos_col - CW'(K - 1);
         end
      end
   end

   assign win_valid  = win_valid_q;
   assign frame_done = frame_done_q;
   assign win_data   = win_data_q;
   assign win_row    = win_row_q;
   assign win_col    = win_col_q;

endmodule
